alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Parametrised, pipelined successor to the 32-bit combinational ALU.
//  - Configurable data width; optional input register stage.
//  - Valid/ready handshake on both sides, with full backpressure.
//  - Adds shift operations and ADC/SBB, chained through an architectural
//    carry register.
//  - Sits between the issue logic and the writeback mux; one op accepted per cycle.
// PARAMETERS
//  WIDTH   32  operand/result width in bits; legal for any WIDTH >= 4
//  IN_REG  1   1: input reg + output reg (latency 2); 0: output reg only (latency 1)
//  SHW     $clog2(WIDTH)  localparam, shift-amount width (b[SHW-1:0])
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      op/operands valid
//  in_ready   out  1      block can accept; transfer when in_valid & in_ready
//  op         in   4      alu_pkg::op_e
//  a, b       in   WIDTH  operands
//  flag_clr   in   1      synchronous clear of carry register
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts; transfer when out_valid & out_ready
//  y          out  WIDTH  result
//  c,o,z,n    out  1      carry/borrow, signed overflow, zero, negative of y
// BEHAVIOUR
//  - Reset (async): out_valid=0, y=0, c=o=z=n=0, stage-A valid=0, carry_q=0.
//    In-flight ops are discarded. in_ready=1 from the first edge after release.
//  - Ops: 0 ADD a+b | 1 SUB a-b | 2 INC a+1 | 3 AND | 4 OR | 5 XOR | 6 NOT ~a
//    7 ADC a+b+carry_q | 8 SBB a-b-carry_q | 9 SHL | 10 SHR | 11 SRA
//    (shift a by b[SHW-1:0]) | 12 CMP (as SUB) | 13-15 undefined.
//  - Arithmetic: computed at WIDTH+1 bits.
//    - ADD/ADC/INC: c=carry-out.
//    - SUB/SBB/CMP: c=borrow (unsigned a < b[+cin]).
//    - o = signed overflow: operands same sign (ADD) or differing sign (SUB),
//      and result sign differs from a.
//  - Logical ops: c=o=0.
//  - Shifts: c = last bit shifted out (0 when shamt=0), o=0.
//  - z=(y==0) and n=y[WIDTH-1] for every op.
//  - Undefined op: y=0, z=1, c=o=n=0.
//  - carry_q:
//    - Loads c when a result enters the output register and op is arithmetic
//      or shift; unchanged otherwise.
//    - flag_clr in the same cycle wins (carry_q=0).
//    - Compute reads carry_q as of that edge, so back-to-back ADCs chain correctly.
//  - Pipeline:
//    - Output reg loads when ~out_valid | out_ready.
//    - IN_REG=1: stage A loads when ~a_valid | out-load.
//    - in_ready = that load condition (combinational from out_ready).
//    - Full throughput 1/cycle; order preserved.
//    - With out_ready=0, the block holds IN_REG+1 ops, then in_ready=0.
//  - y/flags hold stable while out_valid & ~out_ready.
//  - Simultaneous output drain and input accept in the same cycle is legal,
//    with no bubble.
// STRUCTURE
//  - alu_pkg:
//    - op_e (4-bit enum)
//    - flags_t struct {c,o,z,n}
//    - function is_arith(op_e)
//    - function is_shift(op_e)
//  - alu_core: combinational sub-module.
//    - Inputs: (a, b, op, cin).
//    - Outputs: (y, flags_t).
//    - Parametrised by WIDTH.
//  - alu_pipe: handshake, stage regs, carry_q; generate on IN_REG.
// TESTING (WIDTH=32, IN_REG=1 unless stated)
//  1. ADD FFFFFFFF+00000001
//     -> out_valid 2 cycles after accept: y=0, z=1, c=1, o=0, n=0.
//  2. SUB 80000000-00000001 -> y=7FFFFFFF, o=1, c=0, n=0.
//     CMP 00000001,00000002 -> y=FFFFFFFF, c=1, n=1.
//  3. ADD FFFFFFFF+1 then ADC 0+0 back-to-back -> second y=00000001.
//     Repeat with flag_clr pulsed between the ops -> y=0.
//  4. SRA 80000000 by 4 -> y=F8000000, n=1, c=0.
//     SHR 0000000F by 1 -> y=00000007, c=1.
//  5. Hold out_ready=0, drive 3 ops -> in_ready=0 after 2 accepted.
//     Release -> all 3 results emerge in order; none lost or duplicated.
//  6. Assert rst with 2 ops in flight -> out_valid=0 immediately, carry_q=0.
//     Undefined op 4'hF -> y=0, z=1, carry_q unchanged.
//     Repeat 1 with IN_REG=0 -> latency 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode enum, flag bundle and opcode class helpers.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_INC = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_NOT = 4'd6,
        OP_ADC = 4'd7,
        OP_SBB = 4'd8,
        OP_SHL = 4'd9,
        OP_SHR = 4'd10,
        OP_SRA = 4'd11,
        OP_CMP = 4'd12
    } op_e;

    typedef struct packed {
        logic c;
        logic o;
        logic z;
        logic n;
    } flags_t;

    function automatic logic is_arith(input op_e op);
        return op inside {OP_ADD, OP_SUB, OP_INC, OP_ADC, OP_SBB, OP_CMP};
    endfunction

    function automatic logic is_shift(input op_e op);
        return op inside {OP_SHL, OP_SHR, OP_SRA};
    endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Issue-side and writeback-side handshake bundle of the pipelined ALU.
interface alu_pipe_if #(parameter int WIDTH = 32);
    import alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    op_e              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flag_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             c;
    logic             o;
    logic             z;
    logic             n;

    modport master (
        output in_valid, op, a, b, flag_clr, out_ready,
        input  in_ready, out_valid, y, c, o, z, n
    );

    modport slave (
        input  in_valid, op, a, b, flag_clr, out_ready,
        output in_ready, out_valid, y, c, o, z, n
    );
endinterface

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath: arithmetic at WIDTH+1 bits, logical ops and shifts with carry-out.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  op_e              i_op,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_y,
    output flags_t           o_flags
);
    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH:0]   w_ext;
    logic [WIDTH-1:0] w_y;
    logic             w_c;
    logic             w_o;
    logic [SHW-1:0]   w_sh;
    logic [WIDTH:0]   w_cin;

    assign w_sh  = i_b[SHW-1:0];
    assign w_cin = {{WIDTH{1'b0}}, i_cin};

    always_comb begin
        w_ext = '0;
        w_y   = '0;
        w_c   = 1'b0;
        w_o   = 1'b0;
        case (i_op)
            OP_ADD, OP_ADC: begin
                w_ext = {1'b0, i_a} + {1'b0, i_b} + ((i_op == OP_ADC) ? w_cin : '0);
                w_y   = w_ext[WIDTH-1:0];
                w_c   = w_ext[WIDTH];
                w_o   = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_y[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_INC: begin
                w_ext = {1'b0, i_a} + {{WIDTH{1'b0}}, 1'b1};
                w_y   = w_ext[WIDTH-1:0];
                w_c   = w_ext[WIDTH];
                w_o   = ~i_a[WIDTH-1] && w_y[WIDTH-1];
            end
            OP_SUB, OP_CMP, OP_SBB: begin
                // Top bit of the WIDTH+1 difference is the unsigned borrow.
                w_ext = {1'b0, i_a} - {1'b0, i_b} - ((i_op == OP_SBB) ? w_cin : '0);
                w_y   = w_ext[WIDTH-1:0];
                w_c   = w_ext[WIDTH];
                w_o   = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_y[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_AND: w_y = i_a & i_b;
            OP_OR:  w_y = i_a | i_b;
            OP_XOR: w_y = i_a ^ i_b;
            OP_NOT: w_y = ~i_a;
            OP_SHL: begin
                w_ext = {1'b0, i_a} << w_sh;
                w_y   = w_ext[WIDTH-1:0];
                w_c   = w_ext[WIDTH];
            end
            OP_SHR: begin
                w_ext = {i_a, 1'b0} >> w_sh;
                w_y   = w_ext[WIDTH:1];
                w_c   = w_ext[0];
            end
            OP_SRA: begin
                w_ext = $signed({i_a, 1'b0}) >>> w_sh;
                w_y   = w_ext[WIDTH:1];
                w_c   = w_ext[0];
            end
            default: begin
                w_y = '0;
                w_c = 1'b0;
                w_o = 1'b0;
            end
        endcase
    end

    assign o_y       = w_y;
    assign o_flags.c = w_c;
    assign o_flags.o = w_o;
    assign o_flags.z = (w_y == '0);
    assign o_flags.n = w_y[WIDTH-1];
endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU wrapper: optional input stage, output register, valid/ready
// handshake with full backpressure and the architectural carry register.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit IN_REG = 1'b1
) (
    input logic       clk,
    input logic       rst,
    alu_pipe_if.slave bus
);
    logic             r_live;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_y;
    flags_t           r_flags;
    logic             r_carry;

    logic             w_out_load;
    logic             w_c_valid;
    op_e              w_c_op;
    logic [WIDTH-1:0] w_c_a;
    logic [WIDTH-1:0] w_c_b;
    logic [WIDTH-1:0] w_y;
    flags_t           w_flags;

    assign w_out_load = ~r_out_valid | bus.out_ready;

    generate
        if (IN_REG) begin : g_in_reg
            logic             r_a_valid;
            op_e              r_a_op;
            logic [WIDTH-1:0] r_a_a;
            logic [WIDTH-1:0] r_a_b;

            assign bus.in_ready = r_live & (~r_a_valid | w_out_load);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a_valid <= 1'b0;
                    r_a_op    <= OP_ADD;
                    r_a_a     <= '0;
                    r_a_b     <= '0;
                end else if (bus.in_ready) begin
                    r_a_valid <= bus.in_valid;
                    if (bus.in_valid) begin
                        r_a_op <= bus.op;
                        r_a_a  <= bus.a;
                        r_a_b  <= bus.b;
                    end
                end
            end

            assign w_c_valid = r_a_valid;
            assign w_c_op    = r_a_op;
            assign w_c_a     = r_a_a;
            assign w_c_b     = r_a_b;
        end else begin : g_no_reg
            assign bus.in_ready = r_live & w_out_load;
            assign w_c_valid    = r_live & bus.in_valid;
            assign w_c_op       = bus.op;
            assign w_c_a        = bus.a;
            assign w_c_b        = bus.b;
        end
    endgenerate

    alu_core #(.WIDTH(WIDTH)) u_core (
        .i_a     (w_c_a),
        .i_b     (w_c_b),
        .i_op    (w_c_op),
        .i_cin   (r_carry),
        .o_y     (w_y),
        .o_flags (w_flags)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_live      <= 1'b0;
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_flags     <= '0;
            r_carry     <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_out_load) begin
                r_out_valid <= w_c_valid;
                if (w_c_valid) begin
                    r_y     <= w_y;
                    r_flags <= w_flags;
                end
            end
            // An explicit clear beats a carry produced by the op landing this cycle.
            if (bus.flag_clr)
                r_carry <= 1'b0;
            else if (w_out_load && w_c_valid && (is_arith(w_c_op) || is_shift(w_c_op)))
                r_carry <= w_flags.c;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.y         = r_y;
    assign bus.c         = r_flags.c;
    assign bus.o         = r_flags.o;
    assign bus.z         = r_flags.z;
    assign bus.n         = r_flags.n;
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: IN_REG=1 instance for most scenarios, IN_REG=0 for latency.
module tb_alu_pipe;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(32)) bus0 ();
    alu_pipe_if #(.WIDTH(32)) bus1 ();

    alu_pipe #(.WIDTH(32), .IN_REG(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    alu_pipe #(.WIDTH(32), .IN_REG(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    function automatic logic rdy(input bit sel);
        return sel ? bus1.in_ready : bus0.in_ready;
    endfunction

    function automatic logic ov(input bit sel);
        return sel ? bus1.out_valid : bus0.out_valid;
    endfunction

    task automatic drive(input bit sel, input logic v, input op_e op, input logic [31:0] a, input logic [31:0] b);
        if (sel) begin
            bus1.in_valid = v; bus1.op = op; bus1.a = a; bus1.b = b;
        end else begin
            bus0.in_valid = v; bus0.op = op; bus0.a = a; bus0.b = b;
        end
    endtask

    // Issues one op, waits for its result; returns y, {c,o,z,n} and cycles from accept edge.
    task automatic run_op(input bit sel, input op_e op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] y, output logic [3:0] f, output int lat);
        int g;
        @(negedge clk);
        drive(sel, 1'b1, op, a, b);
        g = 0;
        while (!rdy(sel) && g < 10) begin
            @(negedge clk);
            g++;
        end
        if (!rdy(sel)) begin
            n_err++;
            $display("FAIL run_op accept timeout: in_ready=0 after %0d cycles, need 1", g);
        end
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        drive(sel, 1'b0, op, a, b);
        while (!ov(sel) && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        y = sel ? bus1.y : bus0.y;
        f = sel ? {bus1.c, bus1.o, bus1.z, bus1.n} : {bus0.c, bus0.o, bus0.z, bus0.n};
    endtask

    task automatic test_reset;
        #2;
        n_vec++; if (bus0.out_valid !== 1'b0) begin n_err++; $display("FAIL rst out_valid: got %b need 0", bus0.out_valid); end
        n_vec++; if (bus0.y !== 32'h0) begin n_err++; $display("FAIL rst y: got %h need 00000000", bus0.y); end
        n_vec++; if ({bus0.c, bus0.o, bus0.z, bus0.n} !== 4'b0000) begin n_err++; $display("FAIL rst flags: got %b need 0000", {bus0.c, bus0.o, bus0.z, bus0.n}); end
        n_vec++; if (bus0.in_ready !== 1'b0) begin n_err++; $display("FAIL rst in_ready: got %b need 0", bus0.in_ready); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (bus0.in_ready !== 1'b1) begin n_err++; $display("FAIL post-rst in_ready0: got %b need 1", bus0.in_ready); end
        n_vec++; if (bus1.in_ready !== 1'b1) begin n_err++; $display("FAIL post-rst in_ready1: got %b need 1", bus1.in_ready); end
    endtask

    task automatic test_add_latency;
        logic [31:0] y; logic [3:0] f; int lat;
        run_op(1'b0, OP_ADC, 32'h0, 32'h0, y, f, lat);
        n_vec++; if (y !== 32'h0) begin n_err++; $display("FAIL adc carry after reset: got %h need 00000000", y); end
        run_op(1'b0, OP_ADD, 32'hFFFF_FFFF, 32'h1, y, f, lat);
        n_vec++; if (lat !== 2) begin n_err++; $display("FAIL add latency: got %0d need 2", lat); end
        n_vec++; if (y !== 32'h0) begin n_err++; $display("FAIL add y: got %h need 00000000", y); end
        n_vec++; if (f !== 4'b1010) begin n_err++; $display("FAIL add flags: got %b need 1010", f); end
    endtask

    task automatic test_sub_cmp;
        logic [31:0] y; logic [3:0] f; int lat;
        run_op(1'b0, OP_SUB, 32'h8000_0000, 32'h1, y, f, lat);
        n_vec++; if (y !== 32'h7FFF_FFFF) begin n_err++; $display("FAIL sub y: got %h need 7fffffff", y); end
        n_vec++; if (f !== 4'b0100) begin n_err++; $display("FAIL sub flags: got %b need 0100", f); end
        run_op(1'b0, OP_CMP, 32'h1, 32'h2, y, f, lat);
        n_vec++; if (y !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL cmp y: got %h need ffffffff", y); end
        n_vec++; if (f !== 4'b1001) begin n_err++; $display("FAIL cmp flags: got %b need 1001", f); end
        run_op(1'b0, OP_SBB, 32'h5, 32'h2, y, f, lat);
        n_vec++; if (y !== 32'h2) begin n_err++; $display("FAIL sbb y: got %h need 00000002", y); end
        n_vec++; if (f !== 4'b0000) begin n_err++; $display("FAIL sbb flags: got %b need 0000", f); end
        run_op(1'b0, OP_INC, 32'h7FFF_FFFF, 32'h0, y, f, lat);
        n_vec++; if (y !== 32'h8000_0000 || f !== 4'b0101) begin n_err++; $display("FAIL inc: got %h/%b need 80000000/0101", y, f); end
    endtask

    task automatic test_logic_shift;
        logic [31:0] y; logic [3:0] f; int lat;
        run_op(1'b0, OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, y, f, lat);
        n_vec++; if (y !== 32'hF000_F000 || f !== 4'b0001) begin n_err++; $display("FAIL and: got %h/%b need f000f000/0001", y, f); end
        run_op(1'b0, OP_XOR, 32'h1234_5678, 32'h1234_5678, y, f, lat);
        n_vec++; if (y !== 32'h0 || f !== 4'b0010) begin n_err++; $display("FAIL xor: got %h/%b need 00000000/0010", y, f); end
        run_op(1'b0, OP_NOT, 32'h0, 32'h0, y, f, lat);
        n_vec++; if (y !== 32'hFFFF_FFFF || f !== 4'b0001) begin n_err++; $display("FAIL not: got %h/%b need ffffffff/0001", y, f); end
        run_op(1'b0, OP_SRA, 32'h8000_0000, 32'd4, y, f, lat);
        n_vec++; if (y !== 32'hF800_0000 || f !== 4'b0001) begin n_err++; $display("FAIL sra: got %h/%b need f8000000/0001", y, f); end
        run_op(1'b0, OP_SHR, 32'h0000_000F, 32'd1, y, f, lat);
        n_vec++; if (y !== 32'h7 || f !== 4'b1000) begin n_err++; $display("FAIL shr: got %h/%b need 00000007/1000", y, f); end
        run_op(1'b0, OP_SHL, 32'h8000_0001, 32'd1, y, f, lat);
        n_vec++; if (y !== 32'h2 || f !== 4'b1000) begin n_err++; $display("FAIL shl: got %h/%b need 00000002/1000", y, f); end
        run_op(1'b0, OP_SHL, 32'h8000_0005, 32'd0, y, f, lat);
        n_vec++; if (y !== 32'h8000_0005 || f !== 4'b0001) begin n_err++; $display("FAIL shl0: got %h/%b need 80000005/0001", y, f); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] y; logic [3:0] f; int lat;
        @(negedge clk);
        drive(1'b0, 1'b1, OP_ADD, 32'hFFFF_FFFF, 32'h1);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b1, OP_ADC, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, OP_ADD, 32'h0, 32'h0);
        n_vec++; if (bus0.out_valid !== 1'b1 || bus0.y !== 32'h0 || bus0.c !== 1'b1) begin
            n_err++; $display("FAIL b2b add: got v=%b y=%h c=%b need 1/00000000/1", bus0.out_valid, bus0.y, bus0.c);
        end
        @(negedge clk);
        n_vec++; if (bus0.out_valid !== 1'b1 || bus0.y !== 32'h1) begin
            n_err++; $display("FAIL b2b adc: got v=%b y=%h need 1/00000001", bus0.out_valid, bus0.y);
        end
        run_op(1'b0, OP_ADD, 32'hFFFF_FFFF, 32'h1, y, f, lat);
        @(negedge clk);
        bus0.flag_clr = 1'b1;
        @(negedge clk);
        bus0.flag_clr = 1'b0;
        run_op(1'b0, OP_ADC, 32'h0, 32'h0, y, f, lat);
        n_vec++; if (y !== 32'h0 || f !== 4'b0010) begin n_err++; $display("FAIL flag_clr adc: got %h/%b need 00000000/0010", y, f); end
    endtask

    task automatic test_backpressure;
        logic [31:0] got[$];
        logic [31:0] exp[3] = '{32'd2, 32'd4, 32'd6};
        @(negedge clk);
        bus0.out_ready = 1'b0;
        drive(1'b0, 1'b1, OP_ADD, 32'd1, 32'd1);
        @(posedge clk); @(negedge clk);
        drive(1'b0, 1'b1, OP_ADD, 32'd2, 32'd2);
        n_vec++; if (bus0.in_ready !== 1'b1) begin n_err++; $display("FAIL bp 2nd accept: got %b need 1", bus0.in_ready); end
        @(posedge clk); @(negedge clk);
        drive(1'b0, 1'b1, OP_ADD, 32'd3, 32'd3);
        n_vec++; if (bus0.in_ready !== 1'b0) begin n_err++; $display("FAIL bp full: got in_ready %b need 0", bus0.in_ready); end
        @(posedge clk); @(negedge clk);
        n_vec++; if (bus0.in_ready !== 1'b0 || bus0.y !== 32'd2) begin
            n_err++; $display("FAIL bp hold: got rdy=%b y=%h need 0/00000002", bus0.in_ready, bus0.y);
        end
        bus0.out_ready = 1'b1;
        #1;
        n_vec++; if (bus0.in_ready !== 1'b1) begin n_err++; $display("FAIL bp release ready: got %b need 1", bus0.in_ready); end
        if (bus0.out_valid) got.push_back(bus0.y);
        @(posedge clk); @(negedge clk);
        drive(1'b0, 1'b0, OP_ADD, 32'd0, 32'd0);
        for (int k = 0; k < 8; k++) begin
            if (bus0.out_valid) got.push_back(bus0.y);
            @(posedge clk); @(negedge clk);
        end
        n_vec++; if (got.size() !== 3) begin n_err++; $display("FAIL bp count: got %0d results need 3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (i >= got.size()) begin
                n_err++; $display("FAIL bp order[%0d]: missing need %h", i, exp[i]);
            end else if (got[i] !== exp[i]) begin
                n_err++; $display("FAIL bp order[%0d]: got %h need %h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_reset_inflight_undef;
        logic [31:0] y; logic [3:0] f; int lat;
        run_op(1'b0, OP_ADD, 32'hFFFF_FFFF, 32'h1, y, f, lat);
        @(negedge clk);
        bus0.out_ready = 1'b0;
        drive(1'b0, 1'b1, OP_ADD, 32'd1, 32'd1);
        @(posedge clk); @(negedge clk);
        drive(1'b0, 1'b1, OP_ADD, 32'd2, 32'd2);
        @(posedge clk); @(negedge clk);
        drive(1'b0, 1'b0, OP_ADD, 32'd0, 32'd0);
        n_vec++; if (bus0.out_valid !== 1'b1) begin n_err++; $display("FAIL inflight valid: got %b need 1", bus0.out_valid); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if (bus0.out_valid !== 1'b0 || bus0.y !== 32'h0) begin
            n_err++; $display("FAIL async rst: got v=%b y=%h need 0/00000000", bus0.out_valid, bus0.y);
        end
        @(negedge clk);
        rst = 1'b0;
        bus0.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (bus0.out_valid !== 1'b0) begin n_err++; $display("FAIL rst discard: got out_valid %b need 0", bus0.out_valid); end
        run_op(1'b0, OP_ADC, 32'h0, 32'h0, y, f, lat);
        n_vec++; if (y !== 32'h0) begin n_err++; $display("FAIL rst carry_q: got %h need 00000000", y); end
        run_op(1'b0, OP_ADD, 32'hFFFF_FFFF, 32'h1, y, f, lat);
        run_op(1'b0, op_e'(4'hF), 32'h5, 32'h3, y, f, lat);
        n_vec++; if (y !== 32'h0 || f !== 4'b0010) begin n_err++; $display("FAIL undef op: got %h/%b need 00000000/0010", y, f); end
        run_op(1'b0, OP_ADC, 32'h0, 32'h0, y, f, lat);
        n_vec++; if (y !== 32'h1) begin n_err++; $display("FAIL undef keeps carry: got %h need 00000001", y); end
    endtask

    task automatic test_no_in_reg;
        logic [31:0] y; logic [3:0] f; int lat;
        run_op(1'b1, OP_ADD, 32'hFFFF_FFFF, 32'h1, y, f, lat);
        n_vec++; if (lat !== 1) begin n_err++; $display("FAIL noreg latency: got %0d need 1", lat); end
        n_vec++; if (y !== 32'h0 || f !== 4'b1010) begin n_err++; $display("FAIL noreg add: got %h/%b need 00000000/1010", y, f); end
        run_op(1'b1, OP_ADC, 32'h0, 32'h0, y, f, lat);
        n_vec++; if (y !== 32'h1) begin n_err++; $display("FAIL noreg adc: got %h need 00000001", y); end
    endtask

    initial begin
        drive(1'b0, 1'b0, OP_ADD, 32'h0, 32'h0);
        drive(1'b1, 1'b0, OP_ADD, 32'h0, 32'h0);
        bus0.flag_clr = 1'b0; bus0.out_ready = 1'b1;
        bus1.flag_clr = 1'b0; bus1.out_ready = 1'b1;
        test_reset();
        test_add_latency();
        test_sub_cmp();
        test_logic_shift();
        test_back_to_back();
        test_backpressure();
        test_reset_inflight_undef();
        test_no_in_reg();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
